if_fetch_unit: RTL

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the architectural fetch PC and issues one-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents {pc, pc4, instruction, valid} to decode.
- Honours decode stall and EX-resolved redirects (flush), discarding wrong-path responses.

---
 rtl/if_fetch_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. It owns the fetch PC and keeps at most one request
// in flight to instruction memory. Returned words are buffered in a small FIFO
// and presented to decode. Redirects from EX flush the buffer. Any response
// still in flight at a redirect is discarded.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  // instruction memory
  output logic        imem_req_op,
  output logic [31:0] imem_addr_op,
  input  logic        imem_gnt_ip,
  input  logic        imem_rvalid_ip,
  input  logic [31:0] imem_rdata_ip,
  // decode / EX control
  input  logic        stall_ip,
  input  logic        flush_ip,
  input  logic [31:0] redirect_pc_ip,
  // decode side
  output logic        instr_data_valid_op,
  output logic [31:0] instr_data_op,
  output logic [31:0] pc_op,
  output logic [31:0] pc4_op,
  output logic        fetch_misaligned_op
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;

  // StWaitRsp: granted response will be kept; StDrop: granted response is wrong-path
  typedef enum logic [1:0] {StFetch, StWaitRsp, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            req_hold_q, req_hold_d;
  logic            misaligned_q, misaligned_d;

  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            push;
  logic            pop;
  logic            fire;
  logic            rsp_clear;
  logic            slot_claimed;
  logic [OccW-1:0] occupancy;

  // Only the word-select bits of the redirect matter; bit 0 is ignored.
  logic            unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc_ip[0];

  // Decode-side view of the FIFO head.
  always_comb begin
    instr_data_valid_op = (count_q != '0) && !flush_ip;
    instr_data_op       = fifo_instr_q[rd_ptr_q];
    pc_op               = fifo_pc_q[rd_ptr_q];
    pc4_op              = fifo_pc_q[rd_ptr_q] + 32'd4;
    fetch_misaligned_op = misaligned_q;
    imem_addr_op        = fetch_pc_q;
  end

  // Request issue and FSM next state.
  always_comb begin
    state_d      = state_q;
    pop          = instr_data_valid_op && !stall_ip;
    push         = (state_q == StWaitRsp) && imem_rvalid_ip && !flush_ip;
    // A kept response (in flight or landing now) already owns a FIFO slot.
    slot_claimed = (state_q == StWaitRsp);
    // The memory interface is free once any pending response has returned.
    rsp_clear    = (state_q == StFetch) || imem_rvalid_ip;
    occupancy    = OccW'(count_q) - OccW'(pop) + OccW'(slot_claimed);

    // A request already on the bus stays up until granted so its address is stable.
    imem_req_op  = !reset && !flush_ip && rsp_clear &&
                   (req_hold_q || (occupancy < OccW'(FIFO_DEPTH)));
    fire         = imem_req_op && imem_gnt_ip;

    unique case (state_q)
      StFetch: begin
        if (fire) state_d = StWaitRsp;
      end
      StWaitRsp, StDrop: begin
        if (imem_rvalid_ip) state_d = fire ? StWaitRsp : StFetch;
      end
      default: state_d = StFetch;
    endcase

    // A redirect turns any still-unanswered response into one to throw away.
    if (flush_ip) begin
      state_d = ((state_q != StFetch) && !imem_rvalid_ip) ? StDrop : StFetch;
    end

    fetch_pc_d   = fetch_pc_q;
    if (flush_ip) begin
      fetch_pc_d = {redirect_pc_ip[31:2], 2'b00};
    end else if (fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    req_pc_d     = fire ? fetch_pc_q : req_pc_q;
    req_hold_d   = imem_req_op && !imem_gnt_ip;
    misaligned_d = flush_ip && redirect_pc_ip[1];
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_ip) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Fetch control state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StFetch;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      req_hold_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      req_hold_q   <= req_hold_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Instruction buffer; storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        fifo_pc_q[wr_ptr_q]    <= req_pc_q;
        fifo_instr_q[wr_ptr_q] <= imem_rdata_ip;
      end
    end
  end

endmodule
